// File: rtl/m_seq_pkg.sv
// Constants and FSM state encoding shared by the m-sequence generator and checker,
// so both ends always use the same polynomial and widths.
package m_seq_pkg;

   localparam int                LFSR_W  = 10;
   localparam logic [LFSR_W-1:0] TAPS    = 10'h009;
   localparam int                CNT_W   = 11;
   localparam logic [CNT_W-1:0]  SEQ_LEN = 11'd1023;
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_RUN    = 2'd2,
      ST_REPORT = 2'd3
   } state_t;

endpackage

// File: rtl/m_seq_lfsr_step.sv
// One step of the Galois LFSR: next state and the bit it emits.
// This is purely combinational, so the generator and the checker can both use it.
module m_seq_lfsr_step
   import m_seq_pkg::*;
(
   input  logic [LFSR_W-1:0] lfsr,
   output logic [LFSR_W-1:0] nxt,
   output logic              exp_bit
);

   assign nxt     = {lfsr[LFSR_W-2:0], 1'b0} ^ (TAPS & {LFSR_W{lfsr[LFSR_W-1]}});
   assign exp_bit = nxt[LFSR_W-1];

endmodule

// File: rtl/m_seq_checker.sv
// Bit-by-bit checker for the m-sequence stream: regenerates the expected sequence from the seed,
// counts bits and mismatches, and reports pass/len_err once per run.
module m_seq_checker
   import m_seq_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LFSR_W-1:0] seed,
   input  logic              din,
   input  logic              din_valid,
   input  logic              seq_done,
   output logic              busy,
   output logic [CNT_W-1:0]  bit_count,
   output logic [CNT_W-1:0]  err_count,
   output logic              result_valid,
   output logic              pass,
   output logic              len_err
);

   // Observable FSM state for checkers bound to this block.
   state_t            state;
   logic [LFSR_W-1:0] lfsr;
   logic [LFSR_W-1:0] nxt;
   logic              exp_bit;
   logic              take;
   logic              mism;
   logic [CNT_W-1:0]  bc_new;
   logic [CNT_W-1:0]  ec_new;

   m_seq_lfsr_step u_step (
      .lfsr    (lfsr),
      .nxt     (nxt),
      .exp_bit (exp_bit)
   );

   assign busy = (state == ST_ARMED) || (state == ST_RUN);

   // din_valid has no ready: every valid cycle in ARMED/RUN is consumed, one bit per clock.
   always_comb begin
      take   = busy && din_valid;
      mism   = take && (din != exp_bit);
      bc_new = bit_count;
      ec_new = err_count;
      if (take && (bit_count != CNT_MAX)) bc_new = bit_count + 1'b1;
      if (mism && (err_count != CNT_MAX)) ec_new = err_count + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         lfsr         <= '0;
         bit_count    <= '0;
         err_count    <= '0;
         result_valid <= 1'b0;
         pass         <= 1'b0;
         len_err      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         if (state == ST_REPORT) begin
            result_valid <= 1'b1;
            pass         <= (err_count == '0) && !len_err;
            state        <= ST_IDLE;
         end
         if (start) begin
            lfsr      <= seed;
            bit_count <= '0;
            err_count <= '0;
            state     <= ST_ARMED;
            // A restart during REPORT keeps this run's verdict for one cycle; ARMED clears it.
            if (state != ST_REPORT) begin
               pass    <= 1'b0;
               len_err <= 1'b0;
            end
         end else if (busy) begin
            if (state == ST_ARMED) begin
               pass    <= 1'b0;
               len_err <= 1'b0;
            end
            if (take) begin
               lfsr      <= nxt;
               bit_count <= bc_new;
               err_count <= ec_new;
               state     <= ST_RUN;
            end
            if (bc_new > SEQ_LEN) len_err <= 1'b1;
            if (seq_done) begin
               state   <= ST_REPORT;
               len_err <= (bc_new != SEQ_LEN);
            end
         end
      end
   end

endmodule

// File: doc/m_seq_checker.md
Name: m_seq_checker

Overview:
Downstream companion to the 10-bit m-sequence generator. It receives the generator's serial bit stream and end-of-sequence strobe, and regenerates the expected sequence locally from the same seed with the identical Galois LFSR. It compares bit by bit and reports per-run bit count, error count and pass/fail. It is used as the loop-back / BER check stage in the m-sequence test path.

Parameters:
LFSR_W, 10, LFSR width; must match the generator.
TAPS, 10'h009, Galois feedback mask XORed in when the MSB shifts out.
SEQ_LEN, 1023, expected bits per run (2^LFSR_W - 1).
CNT_W, 11, width of the bit and error counters.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset; asynchronous, active-low (0 = reset).
start  in  1  one-cycle pulse, same pulse that arms the generator; loads seed and clears counters.
seed  in  LFSR_W  seed; sampled only on the cycle start=1.
din  in  1  serial bit from the generator.
din_valid  in  1  din qualifier; one bit is consumed per cycle with din_valid=1.
seq_done  in  1  end-of-sequence strobe from the generator.
busy  out  1  1 in ARMED or RUN.
bit_count  out  CNT_W  bits consumed in current/last run.
err_count  out  CNT_W  mismatches in current/last run; saturates at all-ones.
result_valid  out  1  one-cycle pulse when the run result is final.
pass  out  1  held from result_valid until next start: err_count==0 and bit_count==SEQ_LEN.
len_err  out  1  held like pass: seq_done came with bit_count!=SEQ_LEN, or bit_count overran SEQ_LEN.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, lfsr=0, all counters 0, busy=0, result_valid=0, pass=0, len_err=0.
- FSM states are IDLE, ARMED, RUN and REPORT.
- IDLE: start=1 -> lfsr<=seed, counters<=0, pass<=0, len_err<=0, go to ARMED.
- ARMED: the first din_valid=1 -> go to RUN and process that bit.
- RUN: each din_valid=1 processes one bit.
- Bit processing:
  - nxt = {lfsr[LFSR_W-2:0],1'b0} ^ (TAPS & {LFSR_W{lfsr[LFSR_W-1]}}).
  - Expected bit = nxt[LFSR_W-1].
  - lfsr<=nxt.
  - bit_count += 1.
  - If din != expected, err_count += 1, saturating at 2^CNT_W-1.
- No bubbles: back-to-back valid cycles are consumed at 1 bit/clk.
- seq_done=1 in ARMED or RUN -> go to REPORT.
- Same-cycle rule: if din_valid and seq_done are both 1, the bit is processed first. The length check uses the updated bit_count.
- len_err <= (bit_count_final != SEQ_LEN).
- Overrun: bit_count reaching SEQ_LEN+1 before seq_done sets len_err=1 immediately. Counting continues, saturating.
- REPORT lasts one cycle:
  - result_valid=1.
  - pass <= (err_count==0) & ~len_err.
  - Return to IDLE.
- Latency: result_valid is asserted 2 clk after the cycle that seq_done is sampled (1 cycle to REPORT, registered pulse out). bit_count/err_count are stable from the REPORT cycle.
- start in ARMED or RUN aborts the run and restarts: reload seed, clear counters, go to ARMED. No result_valid is issued for the aborted run.
- start coincident with REPORT also restarts. The result_valid pulse still fires that cycle, and pass/len_err are then cleared the next cycle.
- seq_done in IDLE is ignored. din_valid in IDLE or REPORT is ignored.
- Seed 0: the expected stream is all zeros. No special handling; this is legal for stuck-at checks.
- Outputs bit_count and err_count hold their values in IDLE until the next start.

Decomposition:
- Shared package m_seq_pkg holds LFSR_W, TAPS, SEQ_LEN, CNT_W and the FSM state encoding. The generator and checker import the same constants, so the polynomial cannot diverge.
- One natural sub-module: m_seq_lfsr_step, a combinational next-state function (lfsr -> nxt, expected bit). It is reusable by the generator.
- FSM and counters stay in the top.

Test Plan:
1. seed=10'h001: start, drive the generator's own 1023 bits + seq_done -> result_valid once; bit_count=1023, err_count=0, pass=1, len_err=0.
2. Same as 1 with din inverted at bit indices 100 and 700 -> err_count=2, pass=0, len_err=0.
3. Fully inverted stream, seed=10'h2A5 -> err_count=1023, pass=0.
4. seq_done after 500 bits -> bit_count=500, len_err=1, pass=0. A separate run without seq_done for 1030 bits -> len_err=1 at bit 1024.
5. Random din_valid gaps (30% idle), seed=10'h3FF -> identical result to the gapless run. Also check din_valid+seq_done on the final bit -> bit_count=1023, pass=1.
6. rst=0 mid-run at bit 400 -> all outputs 0 asynchronously. start during RUN at bit 300 -> no result_valid; the new run completes with pass=1.
